// File: rtl/gpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gpu_pkg
// Purpose  : State encodings shared by the scheduler, the instruction fetcher
//            and the LSU, plus a small saturating-increment helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package gpu_pkg;

  // Scheduler (core) states
  localparam logic [2:0] CORE_IDLE    = 3'b000;
  localparam logic [2:0] CORE_FETCH   = 3'b001;
  localparam logic [2:0] CORE_DECODE  = 3'b010;
  localparam logic [2:0] CORE_REQUEST = 3'b011;
  localparam logic [2:0] CORE_WAIT    = 3'b100;
  localparam logic [2:0] CORE_EXECUTE = 3'b101;
  localparam logic [2:0] CORE_UPDATE  = 3'b110;
  localparam logic [2:0] CORE_DONE    = 3'b111;

  // Fetcher states
  localparam logic [2:0] FETCHER_IDLE     = 3'b000;
  localparam logic [2:0] FETCHER_FETCHING = 3'b001;
  localparam logic [2:0] FETCHER_FETCHED  = 3'b010;

  // LSU states
  localparam logic [1:0] LSU_IDLE       = 2'b00;
  localparam logic [1:0] LSU_REQUESTING = 2'b01;
  localparam logic [1:0] LSU_WAITING    = 2'b10;
  localparam logic [1:0] LSU_DONE       = 2'b11;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/icache_array.sv
`default_nettype none
// ============================================================================
// Module   : icache_array
// Purpose  : Direct-mapped instruction cache storage (valid / tag / data).
//            Combinational lookup, synchronous single write port, flush that
//            clears every valid bit. Only the valid bits are reset.
// Ports    : clk, reset       - clock, async active-high reset
//            i_flush          - clear all valid bits on the next edge
//            i_rd_addr        - lookup address (PC)
//            o_hit, o_rd_data - lookup result
//            i_wr_en, i_wr_addr, i_wr_data - line fill
// Revision : 1.0 - initial release
// ============================================================================
module icache_array #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 16,
  parameter int LINES     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_flush,
  input  logic [ADDR_BITS-1:0] i_rd_addr,
  output logic                 o_hit,
  output logic [DATA_BITS-1:0] o_rd_data,
  input  logic                 i_wr_en,
  input  logic [ADDR_BITS-1:0] i_wr_addr,
  input  logic [DATA_BITS-1:0] i_wr_data
);

  localparam int INDEX_BITS = $clog2(LINES);
  localparam int TAG_BITS   = ADDR_BITS - INDEX_BITS;

  logic [LINES-1:0]      r_valid;
  logic [DATA_BITS-1:0]  r_data [LINES];
  logic [INDEX_BITS-1:0] w_rd_idx;
  logic [INDEX_BITS-1:0] w_wr_idx;
  logic                  w_tag_match;
  logic                  w_do_write;

  assign w_rd_idx   = i_rd_addr[INDEX_BITS-1:0];
  assign w_wr_idx   = i_wr_addr[INDEX_BITS-1:0];
  // A flush in the same cycle as a fill wins: the line stays untouched.
  assign w_do_write = i_wr_en && !i_flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
    end else if (i_flush) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[w_wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_write) begin
      r_data[w_wr_idx] <= i_wr_data;
    end
  end

  generate
    if (TAG_BITS > 0) begin : g_tag
      logic [TAG_BITS-1:0] r_tag [LINES];

      always_ff @(posedge clk) begin
        if (w_do_write) begin
          r_tag[w_wr_idx] <= i_wr_addr[ADDR_BITS-1:INDEX_BITS];
        end
      end

      assign w_tag_match = (r_tag[w_rd_idx] == i_rd_addr[ADDR_BITS-1:INDEX_BITS]);
    end else begin : g_no_tag
      // Every PC has its own line, so the valid bit alone decides a hit.
      assign w_tag_match = 1'b1;
    end
  endgenerate

  assign o_hit     = r_valid[w_rd_idx] && w_tag_match;
  assign o_rd_data = r_data[w_rd_idx];

endmodule
`default_nettype wire

// File: rtl/instruction_fetcher.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetcher
// Purpose  : Per-core instruction fetcher. Answers the scheduler's FETCH
//            request from a direct-mapped cache (1-cycle hit) or over the
//            program-memory valid/ready channel, then reports FETCHED until
//            the scheduler moves to DECODE. Keeps saturating hit/miss counts.
// Ports    : clk, reset                   - clock, async active-high reset
//            core_state, current_pc       - scheduler request
//            flush                        - invalidate every cache line
//            mem_read_valid/address       - program-memory request
//            mem_read_ready/data          - program-memory response
//            fetcher_state, instruction   - result to scheduler
//            hit_count, miss_count        - saturating statistics
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetcher
  import gpu_pkg::*;
#(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 16,
  parameter int CACHE_LINES           = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  input  logic                             flush,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
  output logic [15:0]                      hit_count,
  output logic [15:0]                      miss_count
);

  logic [2:0]                       r_state;
  logic [2:0]                       w_next_state;
  logic                             r_mem_valid;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] r_mem_addr;
  logic [PROGRAM_MEM_DATA_BITS-1:0] r_instruction;
  logic [15:0]                      r_hit_count;
  logic [15:0]                      r_miss_count;

  logic                             w_cache_hit;
  logic [PROGRAM_MEM_DATA_BITS-1:0] w_cache_data;
  logic                             w_lookup_hit;
  logic                             w_take_hit;
  logic                             w_start_miss;
  logic                             w_fill;

  icache_array #(
    .ADDR_BITS (PROGRAM_MEM_ADDR_BITS),
    .DATA_BITS (PROGRAM_MEM_DATA_BITS),
    .LINES     (CACHE_LINES)
  ) u_icache (
    .clk       (clk),
    .reset     (reset),
    .i_flush   (flush),
    .i_rd_addr (current_pc),
    .o_hit     (w_cache_hit),
    .o_rd_data (w_cache_data),
    .i_wr_en   (w_fill),
    .i_wr_addr (r_mem_addr),
    .i_wr_data (mem_read_data)
  );

  // A lookup coinciding with a flush is treated as a miss.
  assign w_lookup_hit = w_cache_hit && !flush;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= FETCHER_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      FETCHER_IDLE: begin
        if (core_state == CORE_FETCH) begin
          w_next_state = w_lookup_hit ? FETCHER_FETCHED : FETCHER_FETCHING;
        end
      end
      FETCHER_FETCHING: begin
        if (w_fill) begin
          w_next_state = FETCHER_FETCHED;
        end
      end
      FETCHER_FETCHED: begin
        if (core_state == CORE_DECODE) begin
          w_next_state = FETCHER_IDLE;
        end
      end
      default: w_next_state = FETCHER_IDLE;
    endcase
  end

  // Output / datapath control decode
  always_comb begin
    w_take_hit   = 1'b0;
    w_start_miss = 1'b0;
    w_fill       = 1'b0;
    case (r_state)
      FETCHER_IDLE: begin
        if (core_state == CORE_FETCH) begin
          w_take_hit   = w_lookup_hit;
          w_start_miss = !w_lookup_hit;
        end
      end
      FETCHER_FETCHING: begin
        // Ready only counts while a request is actually outstanding.
        w_fill = r_mem_valid && mem_read_ready;
      end
      default: ;
    endcase
  end

  // Memory request, instruction and statistics registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem_valid   <= 1'b0;
      r_mem_addr    <= '0;
      r_instruction <= '0;
      r_hit_count   <= 16'd0;
      r_miss_count  <= 16'd0;
    end else begin
      if (w_start_miss) begin
        r_mem_valid  <= 1'b1;
        r_mem_addr   <= current_pc;
        r_miss_count <= sat_inc16(r_miss_count);
      end
      if (w_take_hit) begin
        r_instruction <= w_cache_data;
        r_hit_count   <= sat_inc16(r_hit_count);
      end
      if (w_fill) begin
        r_mem_valid   <= 1'b0;
        r_instruction <= mem_read_data;
      end
    end
  end

  assign fetcher_state    = r_state;
  assign mem_read_valid   = r_mem_valid;
  assign mem_read_address = r_mem_addr;
  assign instruction      = r_instruction;
  assign hit_count        = r_hit_count;
  assign miss_count       = r_miss_count;

endmodule
`default_nettype wire
